// File: rtl/mux_sel_reg_n.sv
// mux_sel_reg_n: registered N:1 channel selector with valid/ready handshake.
// Define MUX_ARB_RR_EN to add the round-robin arbiter (mode=1) and its ptr register.
module mux_sel_reg_n #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [(2**SEL_W)*DATA_W-1:0]     din,
    input  logic [(2**SEL_W)-1:0]            din_valid,
    output logic [(2**SEL_W)-1:0]            din_ready,
    input  logic [SEL_W-1:0]                 sel,
    input  logic                             mode,
    output logic [DATA_W-1:0]                dout,
    output logic [SEL_W-1:0]                 dout_ch,
    output logic                             dout_valid,
    input  logic                             dout_ready
);
    localparam int N = 2**SEL_W;

    logic              load_en, acc;
    logic [SEL_W-1:0]  g;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [SEL_W-1:0]  dout_ch_q, dout_ch_d;
    logic              dout_valid_q, dout_valid_d;

`ifdef MUX_ARB_RR_EN
    logic [SEL_W-1:0] ptr_q, ptr_d, rr_g, idx;

    // Scan farthest-first so the nearest valid channel after ptr overwrites the rest.
    always_comb begin
        rr_g = ptr_q;
        idx  = '0;
        for (int k = N; k >= 1; k--) begin
            idx = ptr_q + SEL_W'(k);
            if (din_valid[idx]) rr_g = idx;
        end
    end

    assign g     = mode ? rr_g : sel;
    assign ptr_d = (acc && mode) ? g : ptr_q;

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= SEL_W'(N - 1);
        else     ptr_q <= ptr_d;
    end
`else
    logic mode_unused;

    assign mode_unused = mode;
    assign g           = sel;
`endif

    assign load_en = !dout_valid_q || dout_ready;
    assign acc     = !rst && load_en && din_valid[g];

    always_comb begin
        din_ready    = acc ? (N'(1) << g) : '0;
        dout_d       = acc ? din[g*DATA_W +: DATA_W] : dout_q;
        dout_ch_d    = acc ? g : dout_ch_q;
        dout_valid_d = acc || (dout_valid_q && !dout_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q       <= '0;
            dout_ch_q    <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_ch_q    <= dout_ch_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_ch    = dout_ch_q;
    assign dout_valid = dout_valid_q;
endmodule

// File: tb/tb_mux_sel_reg_n.sv
// tb_mux_sel_reg_n: directed bench for mux_sel_reg_n (default 8 x 32-bit).
// Round-robin steps are compiled in when MUX_ARB_RR_EN is defined.
module tb_mux_sel_reg_n;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 3;
    localparam int N      = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*DATA_W-1:0] din;
    logic [N-1:0]      din_valid, din_ready;
    logic [SEL_W-1:0]  sel, dout_ch;
    logic              mode, dout_valid, dout_ready;
    logic [DATA_W-1:0] dout;
    logic              flip;
    int                n_chk = 0;
    int                n_fail = 0;

    mux_sel_reg_n #(.DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .sel(sel), .mode(mode), .dout(dout), .dout_ch(dout_ch),
        .dout_valid(dout_valid), .dout_ready(dout_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] word(input int i, input logic f);
        logic [3:0] n4;
        n4 = 4'(i);
        return {8{n4}} ^ {DATA_W{f}};
    endfunction

    always_comb begin
        din = '0;
        for (int i = 0; i < N; i++) din[i*DATA_W +: DATA_W] = word(i, flip);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [SEL_W-1:0] s, input logic m,
                         input logic dr, input logic r);
        @(negedge clk);
        din_valid = v; sel = s; mode = m; dout_ready = dr; rst = r;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [DATA_W-1:0] d,
                           input logic [SEL_W-1:0] c, input logic v);
        chk({tag, "_dout"}, dout, d);
        chk({tag, "_ch"}, 32'(dout_ch), 32'(c));
        chk({tag, "_valid"}, 32'(dout_valid), 32'(v));
    endtask

    initial begin
        flip = 1'b0;
        rst = 1'b1; din_valid = '1; sel = '0; mode = 1'b0; dout_ready = 1'b0;
        drive('1, 0, 0, 0, 1);
        chk("rst_ready", 32'(din_ready), 0);
        tick;
        drive('1, 0, 0, 0, 1);
        chk("rst_ready2", 32'(din_ready), 0);
        tick;
        chk_out("rst", 0, 0, 0);

        drive('1, 5, 0, 0, 0);
        chk("sel5_ready", 32'(din_ready), 32'h20);
        tick;
        chk_out("sel5", 32'h5555_5555, 5, 1);

        drive(8'hF7, 3, 0, 1, 0);
        chk("stall_ready", 32'(din_ready), 0);
        tick;
        chk_out("drain", 32'h5555_5555, 5, 0);
        drive(8'hF7, 3, 0, 0, 0);
        chk("stall_ready2", 32'(din_ready), 0);
        tick;
        chk("stall_valid", 32'(dout_valid), 0);
        drive(8'hFF, 3, 0, 0, 0);
        chk("ch3_ready", 32'(din_ready), 32'h08);
        tick;
        chk_out("ch3", 32'h3333_3333, 3, 1);

        for (int k = 0; k < 4; k++) begin
            flip = k[0];
            drive('1, SEL_W'(k * 5 + 1), 0, 0, 0);
            chk("bp_ready", 32'(din_ready), 0);
            tick;
            chk_out("bp", 32'h3333_3333, 3, 1);
        end
        flip = 1'b0;
        drive('1, 6, 0, 1, 0);
        chk("b2b_ready", 32'(din_ready), 32'h40);
        tick;
        chk_out("b2b6", 32'h6666_6666, 6, 1);
        flip = 1'b1;
        drive('1, 2, 0, 1, 0);
        chk("b2b_ready2", 32'(din_ready), 32'h04);
        tick;
        chk_out("b2b2", 32'hDDDD_DDDD, 2, 1);
        flip = 1'b0;
        drive('0, 2, 0, 1, 0);
        tick;
        chk_out("empty", 32'hDDDD_DDDD, 2, 0);

        drive('1, 4, 0, 0, 0);
        tick;
        chk_out("hold4", 32'h4444_4444, 4, 1);
        drive('1, 4, 0, 0, 1);
        chk("midrst_ready", 32'(din_ready), 0);
        tick;
        chk_out("midrst", 0, 0, 0);

`ifdef MUX_ARB_RR_EN
        for (int k = 0; k < 9; k++) begin
            drive('1, 5, 1, 1, 0);
            chk("rr_ready", 32'(din_ready), 32'(1) << (k % 8));
            tick;
            chk("rr_seq", 32'(dout_ch), 32'(k % 8));
        end
        for (int k = 0; k < 4; k++) begin
            drive(8'h90, 0, 1, 1, 0);
            tick;
            chk("rr_4_7", 32'(dout_ch), k[0] ? 7 : 4);
        end
        drive(8'h04, 0, 1, 1, 0);
        tick;
        chk("rr_ptr2", 32'(dout_ch), 2);
        for (int k = 0; k < 3; k++) begin
            drive(8'h03, 7, 1, 1, 0);
            tick;
            chk("rr_skip", 32'(dout_ch), k[0] ? 1 : 0);
        end
        drive('1, 0, 1, 0, 0);
        tick;
        drive('1, 0, 1, 0, 1);
        tick;
        chk_out("rr_rst", 0, 0, 0);
        drive('1, 6, 1, 1, 0);
        tick;
        chk_out("rr_after_rst", 32'h0000_0000, 0, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
